// File: rtl/cam_pixel_packer.sv
`default_nettype none
// ============================================================================
// cam_pixel_packer : camera bytes -> cropped RGB565 queue words + frame status
// Rev 1.0
// ============================================================================
module cam_pixel_packer #(
  parameter int FRAME_WIDTH  = 480,
  parameter int FRAME_HEIGHT = 272
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              cam_vsync,
  input  logic                              cam_href,
  input  logic [7:0]                        cam_data,
  input  logic                              cam_data_valid,
  input  logic                              queue_full,
  output logic [16:0]                       queue_data_out,
  output logic                              queue_wr_en,
  output logic                              frame_done,
  output logic                              frame_err,
  output logic [$clog2(FRAME_HEIGHT+1)-1:0] line_count,
  output logic [7:0]                        drop_count
);

  localparam int LW = $clog2(FRAME_HEIGHT + 1);
  localparam int CW = $clog2(FRAME_WIDTH + 1);
  localparam logic [LW-1:0] ROW_MAX = LW'(FRAME_HEIGHT);
  localparam logic [CW-1:0] COL_MAX = CW'(FRAME_WIDTH);
  localparam logic [16:0]   SOF_WORD = 17'h10000;

  typedef enum logic [1:0] {WAIT_SOF, SEND_SOF, ACTIVE, DROP} state_t;

  state_t        state_q;
  logic          vsync_q, href_q, phase_q, frame_err_q;
  logic [7:0]    hi_q;
  logic [CW-1:0] col_q;
  logic [LW-1:0] row_q;
  logic          wr_en_q, done_q, err_out_q;
  logic [16:0]   data_q;
  logic [LW-1:0] lines_q;
  logic [7:0]    drop_q;

  logic          vs_rise_d, vs_fall_d, href_fall_d, byte_ok_d, in_win_d;
  logic          end_d, end_err_d;
  logic [LW-1:0] row_d;

  always_comb begin
    vs_rise_d   = cam_vsync & ~vsync_q;
    vs_fall_d   = ~cam_vsync & vsync_q;
    href_fall_d = href_q & ~cam_href;
    byte_ok_d   = cam_data_valid & cam_href;
    in_win_d    = (col_q < COL_MAX) && (row_q < ROW_MAX);
    // A line closing in the same cycle as the frame end still counts.
    row_d = (href_fall_d && col_q != '0 && row_q < ROW_MAX) ? row_q + LW'(1) : row_q;
    end_d = (vs_rise_d && state_q != WAIT_SOF) ||
            (vs_fall_d && (state_q == ACTIVE || state_q == DROP));
    end_err_d = frame_err_q | vs_fall_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_SOF;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase_q     <= 1'b0;
      frame_err_q <= 1'b0;
      hi_q        <= '0;
      col_q       <= '0;
      row_q       <= '0;
      wr_en_q     <= 1'b0;
      done_q      <= 1'b0;
      err_out_q   <= 1'b0;
      data_q      <= '0;
      lines_q     <= '0;
      drop_q      <= '0;
    end else begin
      vsync_q <= cam_vsync;
      href_q  <= cam_href;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      if (end_d) begin
        done_q    <= 1'b1;
        err_out_q <= end_err_d;
        lines_q   <= row_d;
        if (end_err_d && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        if (vs_fall_d) begin
          state_q     <= SEND_SOF;
          frame_err_q <= 1'b0;
          phase_q     <= 1'b0;
          col_q       <= '0;
          row_q       <= '0;
        end else begin
          state_q <= WAIT_SOF;
        end
      end else begin
        case (state_q)
          WAIT_SOF: begin
            if (vs_fall_d) begin
              state_q     <= SEND_SOF;
              frame_err_q <= 1'b0;
              phase_q     <= 1'b0;
              col_q       <= '0;
              row_q       <= '0;
            end
          end
          SEND_SOF: begin
            if (queue_full) begin
              frame_err_q <= 1'b1;
              state_q     <= DROP;
            end else begin
              wr_en_q <= 1'b1;
              data_q  <= SOF_WORD;
              state_q <= ACTIVE;
            end
          end
          ACTIVE, DROP: begin
            if (href_fall_d) begin
              phase_q <= 1'b0;
              col_q   <= '0;
              row_q   <= row_d;
            end
            if (state_q == ACTIVE && byte_ok_d) begin
              if (!phase_q) begin
                hi_q    <= cam_data;
                phase_q <= 1'b1;
              end else begin
                phase_q <= 1'b0;
                if (in_win_d) begin
                  col_q <= col_q + CW'(1);
                  if (queue_full) begin
                    frame_err_q <= 1'b1;
                    state_q     <= DROP;
                  end else begin
                    wr_en_q <= 1'b1;
                    data_q  <= {1'b0, hi_q, cam_data};
                  end
                end
              end
            end
          end
          default: state_q <= WAIT_SOF;
        endcase
      end
    end
  end

  assign queue_data_out = data_q;
  assign queue_wr_en    = wr_en_q;
  assign frame_done     = done_q;
  assign frame_err      = err_out_q;
  assign line_count     = lines_q;
  assign drop_count     = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_pixel_packer.sv
`default_nettype none
// ============================================================================
// tb_cam_pixel_packer : directed bench for cam_pixel_packer (23x17 frame)
// Rev 1.0
// ============================================================================
module tb_cam_pixel_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        cam_data_valid = 1'b0;
  logic        queue_full = 1'b0;
  logic [16:0] queue_data_out;
  logic        queue_wr_en;
  logic        frame_done;
  logic        frame_err;
  logic [4:0]  line_count;
  logic [7:0]  drop_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [16:0] wr_log[$];
  int          done_cnt = 0;
  logic        last_err = 1'b0;
  logic [4:0]  last_lines = '0;
  int          full_viol = 0;
  logic        full_at_edge = 1'b0;

  cam_pixel_packer #(
    .FRAME_WIDTH (23),
    .FRAME_HEIGHT(17)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .cam_vsync     (cam_vsync),
    .cam_href      (cam_href),
    .cam_data      (cam_data),
    .cam_data_valid(cam_data_valid),
    .queue_full    (queue_full),
    .queue_data_out(queue_data_out),
    .queue_wr_en   (queue_wr_en),
    .frame_done    (frame_done),
    .frame_err     (frame_err),
    .line_count    (line_count),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  // Queue-side observer: logs writes, frame status, and writes decided while full.
  always @(posedge clk) full_at_edge <= queue_full;
  always @(negedge clk) begin
    if (queue_wr_en) begin
      wr_log.push_back(queue_data_out);
      if (full_at_edge) full_viol++;
    end
    if (frame_done) begin
      done_cnt++;
      last_err   = frame_err;
      last_lines = line_count;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vs_fall();
    @(negedge clk); cam_vsync = 1'b0;
    idle(3);
  endtask

  task automatic vs_rise();
    @(negedge clk); cam_vsync = 1'b1;
    idle(3);
  endtask

  // full_from: pixel index (1-based) at which queue_full is raised; 0 = never
  task automatic send_line(input int npix, input logic [7:0] hi, input logic [7:0] lo,
                           input int full_from);
    @(negedge clk); cam_href = 1'b1;
    for (int i = 0; i < npix; i++) begin
      @(negedge clk);
      if (full_from != 0 && i + 1 == full_from) queue_full = 1'b1;
      cam_data = hi; cam_data_valid = 1'b1;
      @(negedge clk); cam_data = lo;
    end
    @(negedge clk); cam_data_valid = 1'b0; cam_href = 1'b0;
    idle(2);
  endtask

  task automatic send_raw(input int n, input logic [7:0] base, input logic [7:0] step,
                          input logic close_vsync);
    logic [7:0] b;
    b = base;
    @(negedge clk); cam_href = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); cam_data = b; cam_data_valid = 1'b1;
      b = b + step;
    end
    @(negedge clk); cam_data_valid = 1'b0; cam_href = 1'b0;
    if (close_vsync) cam_vsync = 1'b1;
    idle(3);
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_wr_en", queue_wr_en, 0);
    chk("rst_data", queue_data_out, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_drop", drop_count, 0);
    @(negedge clk); reset = 1'b0;
    idle(3);
    chk("no_wr_before_sof", wr_log.size(), 0);

    // 1: SOF two cycles after vsync fall
    @(negedge clk); cam_vsync = 1'b0;
    @(posedge clk); #1;
    chk("sof_not_early", queue_wr_en, 0);
    @(posedge clk); #1;
    chk("sof_wr_en", queue_wr_en, 1);
    chk("sof_word", queue_data_out, 17'h10000);
    idle(3);
    chk("sof_count", wr_log.size(), 1);
    wr_log.delete();

    // 2: three F81F pixels, frame end
    send_line(3, 8'hF8, 8'h1F, 0);
    chk("px3_count", wr_log.size(), 3);
    for (int i = 0; i < 3; i++) chk("px_word", wr_log[i], 17'h0F81F);
    vs_rise();
    chk("f2_done", done_cnt, 1);
    chk("f2_lines", last_lines, 1);
    chk("f2_err", last_err, 0);

    // odd trailing byte, empty line, href fall together with vsync rise
    vs_fall(); wr_log.delete();
    send_raw(5, 8'h12, 8'h22, 1'b0);
    @(negedge clk); cam_href = 1'b1;
    @(negedge clk); cam_href = 1'b0;
    idle(2);
    send_raw(2, 8'hAB, 8'h22, 1'b1);
    chk("odd_count", wr_log.size(), 3);
    chk("odd_w0", wr_log[0], 17'h01234);
    chk("odd_w1", wr_log[1], 17'h05678);
    chk("odd_w2", wr_log[2], 17'h0ABCD);
    chk("odd_lines", last_lines, 2);
    chk("odd_err", last_err, 0);

    // 3: crop 20 lines x 30 pixels to 17 x 23
    wr_log.delete();
    vs_fall();
    for (int l = 0; l < 20; l++) send_line(30, 8'(l), 8'h55, 0);
    chk("crop_count", wr_log.size(), 1 + 17 * 23);
    chk("crop_last", wr_log[wr_log.size() - 1], {1'b0, 8'd16, 8'h55});
    vs_rise();
    chk("crop_lines", last_lines, 17);
    chk("crop_err", last_err, 0);

    // 4: overflow from 5th pixel
    wr_log.delete();
    vs_fall();
    send_line(10, 8'h12, 8'h34, 5);
    queue_full = 1'b0;
    send_line(3, 8'h56, 8'h78, 0);
    chk("ovf_count", wr_log.size(), 5);
    vs_rise();
    chk("ovf_err", last_err, 1);
    chk("ovf_drop", drop_count, 1);
    wr_log.delete();
    vs_fall();
    send_line(2, 8'h9A, 8'hBC, 0);
    vs_rise();
    chk("clean_count", wr_log.size(), 3);
    chk("clean_err", last_err, 0);
    chk("clean_drop", drop_count, 1);

    // 5: full at SOF, drop counter saturation
    wr_log.delete();
    @(negedge clk); queue_full = 1'b1;
    vs_fall();
    vs_rise();
    chk("nosof_count", wr_log.size(), 0);
    chk("nosof_err", last_err, 1);
    chk("nosof_drop", drop_count, 2);
    for (int f = 0; f < 255; f++) begin
      vs_fall();
      vs_rise();
    end
    chk("drop_sat", drop_count, 255);
    @(negedge clk); queue_full = 1'b0;

    // 6: reset mid-line
    vs_fall();
    @(negedge clk); cam_href = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); cam_data = 8'h3C; cam_data_valid = 1'b1;
      @(negedge clk); cam_data = 8'hC3;
    end
    @(negedge clk); cam_data = 8'h3C;
    chk("pre_rst_data", queue_data_out, 17'h03CC3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_data", queue_data_out, 0);
    chk("mid_rst_wr_en", queue_wr_en, 0);
    chk("mid_rst_err", frame_err, 0);
    chk("mid_rst_drop", drop_count, 0);
    chk("mid_rst_done", frame_done, 0);
    chk("mid_rst_lines", line_count, 0);
    wr_log.delete();
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); cam_data = 8'h11; cam_data_valid = 1'b1;
      @(negedge clk); cam_data = 8'h22;
    end
    @(negedge clk); cam_data_valid = 1'b0; cam_href = 1'b0;
    idle(3);
    chk("post_rst_nowr", wr_log.size(), 0);
    vs_rise();
    vs_fall();
    chk("post_rst_sof", wr_log.size(), 1);

    chk("no_wr_when_full", full_viol, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
